// File: rtl/iter_cmp_unit_if.sv
// Request/response bundle for iter_cmp_unit. Signal names take the unit's point of view:
// i_* signals flow into the comparator and o_* signals flow out of it.
interface iter_cmp_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_rs1;
    logic [WIDTH-1:0] i_rs2;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_lt;
    logic             o_eq;
    logic             o_illegal;

    modport master (
        output i_valid, i_op, i_rs1, i_rs2, i_ready,
        input  o_ready, o_valid, o_result, o_lt, o_eq, o_illegal
    );

    modport slave (
        input  i_valid, i_op, i_rs1, i_rs2, i_ready,
        output o_ready, o_valid, o_result, o_lt, o_eq, o_illegal
    );
endinterface

// File: rtl/iter_cmp_unit.sv
// Multi-cycle RISC-V compare unit: walks the operands CHUNK bits per cycle from the MSB end
// and stops at the first differing chunk. WIDTH must be a multiple of CHUNK.
module iter_cmp_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    iter_cmp_unit_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IDXW-1:0]  r_idx;
    logic             r_result;
    logic             r_lt;
    logic             r_eq;
    logic             r_illegal;

    logic [CHUNK-1:0] w_chunk_a [NCHUNK];
    logic [CHUNK-1:0] w_chunk_b [NCHUNK];
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_diff;
    logic             w_lt;
    logic             w_eq;
    logic             w_done;
    logic             w_res;
    logic [WIDTH-1:0] w_flip;

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign w_chunk_a[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_chunk_b[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_ca   = w_chunk_a[r_idx];
    assign w_cb   = w_chunk_b[r_idx];
    assign w_diff = (w_ca != w_cb);
    assign w_lt   = (w_ca < w_cb);
    assign w_eq   = ~w_diff;
    assign w_done = w_diff | (r_idx == '0);

    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign w_flip = (bus.i_op[2:1] == 2'b11) ? '0 : MSB_MASK;

    always_comb begin
        w_res = 1'b0;
        case (r_op)
            3'b000:         w_res = w_eq;
            3'b001:         w_res = ~w_eq;
            3'b100, 3'b110: w_res = w_lt;
            3'b101, 3'b111: w_res = ~w_lt;
            default:        w_res = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_idx     <= '0;
            r_result  <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
            r_illegal <= 1'b0;
        end else if (i_flush) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_result  <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_a     <= bus.i_rs1 ^ w_flip;
                        r_b     <= bus.i_rs2 ^ w_flip;
                        r_op    <= bus.i_op;
                        r_idx   <= IDXW'(NCHUNK - 1);
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_done) begin
                        r_lt      <= w_lt;
                        r_eq      <= w_eq;
                        r_result  <= w_res;
                        r_illegal <= (r_op[2:1] == 2'b01);
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.i_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ready   = (r_state == S_IDLE);
    assign bus.o_valid   = (r_state == S_DONE);
    assign bus.o_result  = {{(WIDTH-1){1'b0}}, r_result};
    assign bus.o_lt      = r_lt;
    assign bus.o_eq      = r_eq;
    assign bus.o_illegal = r_illegal;
endmodule
